loadable_down_timer: RTL and testbench

//   Countdown counterpart to the team's loadable up-counter. Accepts a start value over a

---
 rtl/timer_pkg.sv | 14 +
 rtl/loadable_down_timer_if.sv | 26 ++
 rtl/sat_counter.sv | 21 ++
 rtl/loadable_down_timer.sv | 108 ++++++++++
 tb/tb_loadable_down_timer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types for the timer family: FSM state encoding.
package timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } timer_state_t;

endpackage

// File: rtl/loadable_down_timer_if.sv
// Start handshake, control levels and status outputs of loadable_down_timer.
interface loadable_down_timer_if #(
  parameter int W     = 4,
  parameter int EXP_W = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [W-1:0]     start_val;
  logic             reload_en;
  logic             pause;
  logic             abort;
  logic [W-1:0]     count;
  logic             busy;
  logic             expire;
  logic [EXP_W-1:0] expire_cnt;

  modport master (
    output start_valid, start_val, reload_en, pause, abort,
    input  start_ready, count, busy, expire, expire_cnt
  );

  modport slave (
    input  start_valid, start_val, reload_en, pause, abort,
    output start_ready, count, busy, expire, expire_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects inc one edge later.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_or_load,
  input  logic             inc,
  output logic [EXP_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst_or_load) begin
    if (rst_or_load) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + EXP_W'(1);
    end
  end

endmodule

// File: rtl/loadable_down_timer.sv
// Purpose: loadable countdown timer, one-shot or auto-reload, with pause/abort.
// Latency: start_val=N accepted at edge 0 gives expire after edge N (zero: after edge 0).
// Backpressure: start_ready only in IDLE with abort low; busy blocks new starts.
module loadable_down_timer
  import timer_pkg::*;
#(
  parameter int W     = 4,
  parameter int EXP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_or_load,
  loadable_down_timer_if.slave tif
);

  localparam logic [W-1:0] ONE = W'(1);

  timer_state_t state_q, state_nxt;
  logic [W-1:0] count_q, count_nxt;
  logic [W-1:0] reload_q, reload_nxt;
  logic         expire_q, expire_nxt;
  logic         exp_inc;
  logic         start_ready;
  logic         accept;

  assign start_ready = (state_q == IDLE) && !tif.abort;
  assign accept      = tif.start_valid && start_ready;

  always_ff @(posedge clk or posedge rst_or_load) begin
    if (rst_or_load) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      expire_q <= expire_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    expire_nxt = 1'b0;
    exp_inc    = 1'b0;

    if (tif.abort) begin
      // Abort beats both a pending start and the final decrement.
      count_nxt = '0;
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            count_nxt  = tif.start_val;
            reload_nxt = tif.start_val;
            if (tif.start_val == '0) begin
              expire_nxt = 1'b1;
              exp_inc    = 1'b1;
            end else begin
              state_nxt = tif.pause ? PAUSE : RUN;
            end
          end
        end
        RUN, PAUSE: begin
          if (tif.pause) begin
            state_nxt = PAUSE;
          end else if (count_q > ONE) begin
            count_nxt = count_q - ONE;
            state_nxt = RUN;
          end else if (count_q == ONE) begin
            expire_nxt = 1'b1;
            exp_inc    = 1'b1;
            if (tif.reload_en) begin
              count_nxt = reload_q;
              state_nxt = RUN;
            end else begin
              count_nxt = '0;
              state_nxt = IDLE;
            end
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  sat_counter #(.EXP_W(EXP_W)) u_exp_cnt (
    .clk         (clk),
    .rst_or_load (rst_or_load),
    .inc         (exp_inc),
    .cnt         (tif.expire_cnt)
  );

  assign tif.start_ready = start_ready;
  assign tif.count       = count_q;
  assign tif.busy        = (state_q != IDLE);
  assign tif.expire      = expire_q;

endmodule

// File: tb/tb_loadable_down_timer.sv
// Directed bench for loadable_down_timer; second instance with EXP_W=2 for saturation.
module tb_loadable_down_timer;

  logic clk;
  logic rst;
  logic rst2;
  int   errors;
  int   checks;

  loadable_down_timer_if #(.W(4), .EXP_W(8)) tif ();
  loadable_down_timer_if #(.W(4), .EXP_W(2)) sif ();

  loadable_down_timer #(.W(4), .EXP_W(8)) u_dut (
    .clk         (clk),
    .rst_or_load (rst),
    .tif         (tif)
  );

  loadable_down_timer #(.W(4), .EXP_W(2)) u_sat (
    .clk         (clk),
    .rst_or_load (rst2),
    .tif         (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    tif.start_valid = 1'b0;
    tif.start_val   = 4'd0;
    tif.reload_en   = 1'b0;
    tif.pause       = 1'b0;
    tif.abort       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (tif.count !== 4'd0 || tif.busy !== 1'b0 || tif.expire !== 1'b0 || tif.expire_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got count=%0d busy=%b expire=%b cnt=%0d, want 0/0/0/0",
               tif.count, tif.busy, tif.expire, tif.expire_cnt);
    end
    checks++;
    if (tif.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", tif.start_ready);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_oneshot();
    pulse_reset();
    tif.start_val = 4'd5; tif.start_valid = 1'b1; tif.reload_en = 1'b0;
    step();
    tif.start_valid = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) step();
      checks++;
      if (tif.count !== 4'(5 - i) || tif.expire !== (i == 5)) begin
        errors++;
        $display("FAIL oneshot_edge%0d: got count=%0d expire=%b, want count=%0d expire=%b",
                 i, tif.count, tif.expire, 5 - i, (i == 5));
      end
    end
    checks++;
    if (tif.busy !== 1'b0 || tif.expire_cnt !== 8'd1) begin
      errors++;
      $display("FAIL oneshot_end: got busy=%b cnt=%0d, want busy=0 cnt=1", tif.busy, tif.expire_cnt);
    end
  endtask

  task automatic test_reload();
    logic [3:0] exp_c;
    pulse_reset();
    tif.start_val = 4'd3; tif.start_valid = 1'b1; tif.reload_en = 1'b1;
    step();
    tif.start_valid = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp_c = (e % 3 == 0) ? 4'd3 : 4'(3 - (e % 3));
      checks++;
      if (tif.count !== exp_c || tif.expire !== (e % 3 == 0) || tif.busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_edge%0d: got count=%0d expire=%b busy=%b, want count=%0d expire=%b busy=1",
                 e, tif.count, tif.expire, tif.busy, exp_c, (e % 3 == 0));
      end
    end
    checks++;
    if (tif.expire_cnt !== 8'd3) begin
      errors++;
      $display("FAIL reload_cnt: got %0d want 3", tif.expire_cnt);
    end
    tif.abort = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_pause();
    pulse_reset();
    tif.start_val = 4'd4; tif.start_valid = 1'b1;
    step();
    tif.start_valid = 1'b0;
    step();
    step();
    checks++;
    if (tif.count !== 4'd2) begin
      errors++;
      $display("FAIL pause_pre: got count=%0d want 2", tif.count);
    end
    tif.pause = 1'b1;
    for (int e = 3; e <= 5; e++) begin
      step();
      checks++;
      if (tif.count !== 4'd2 || tif.busy !== 1'b1 || tif.expire !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold_edge%0d: got count=%0d busy=%b expire=%b, want 2/1/0",
                 e, tif.count, tif.busy, tif.expire);
      end
    end
    tif.pause = 1'b0;
    step();
    checks++;
    if (tif.count !== 4'd1 || tif.expire !== 1'b0) begin
      errors++;
      $display("FAIL pause_edge6: got count=%0d expire=%b, want 1/0", tif.count, tif.expire);
    end
    step();
    checks++;
    if (tif.count !== 4'd0 || tif.expire !== 1'b1 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_edge7: got count=%0d expire=%b busy=%b, want 0/1/0",
               tif.count, tif.expire, tif.busy);
    end
  endtask

  task automatic test_abort();
    pulse_reset();
    tif.start_val = 4'd2; tif.start_valid = 1'b1;
    step();
    tif.start_valid = 1'b0;
    step();
    tif.abort = 1'b1; tif.start_valid = 1'b1; tif.start_val = 4'd7;
    #1;
    checks++;
    if (tif.count !== 4'd1 || tif.start_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: got count=%0d ready=%b, want 1/0", tif.count, tif.start_ready);
    end
    step();
    checks++;
    if (tif.count !== 4'd0 || tif.busy !== 1'b0 || tif.expire !== 1'b0 || tif.expire_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_last: got count=%0d busy=%b expire=%b cnt=%0d, want 0/0/0/0",
               tif.count, tif.busy, tif.expire, tif.expire_cnt);
    end
    checks++;
    if (tif.start_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_ready: got %b want 0", tif.start_ready);
    end
    step();
    checks++;
    if (tif.busy !== 1'b0 || tif.count !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle_start: got busy=%b count=%0d, want 0/0", tif.busy, tif.count);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    tif.start_val = 4'd5; tif.start_valid = 1'b1;
    step();
    tif.start_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (tif.count !== 4'd2) begin
      errors++;
      $display("FAIL areset_pre: got count=%0d want 2", tif.count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tif.count !== 4'd0 || tif.busy !== 1'b0 || tif.expire !== 1'b0 || tif.expire_cnt !== 8'd0) begin
      errors++;
      $display("FAIL areset_async: got count=%0d busy=%b expire=%b cnt=%0d, want 0/0/0/0",
               tif.count, tif.busy, tif.expire, tif.expire_cnt);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if (tif.expire !== 1'b0 || tif.busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_after: got expire=%b busy=%b, want 0/0", tif.expire, tif.busy);
    end
    tif.start_val = 4'd2; tif.start_valid = 1'b1;
    step();
    tif.start_valid = 1'b0;
    step();
    checks++;
    if (tif.count !== 4'd1 || tif.expire !== 1'b0) begin
      errors++;
      $display("FAIL areset_restart1: got count=%0d expire=%b, want 1/0", tif.count, tif.expire);
    end
    step();
    checks++;
    if (tif.expire !== 1'b1 || tif.expire_cnt !== 8'd1) begin
      errors++;
      $display("FAIL areset_restart2: got expire=%b cnt=%0d, want 1/1", tif.expire, tif.expire_cnt);
    end
  endtask

  task automatic test_zero_start();
    pulse_reset();
    tif.start_val = 4'd0; tif.start_valid = 1'b1; tif.reload_en = 1'b1;
    step();
    tif.start_valid = 1'b0;
    checks++;
    if (tif.expire !== 1'b1 || tif.busy !== 1'b0 || tif.count !== 4'd0 || tif.expire_cnt !== 8'd1) begin
      errors++;
      $display("FAIL zero_expire: got expire=%b busy=%b count=%0d cnt=%0d, want 1/0/0/1",
               tif.expire, tif.busy, tif.count, tif.expire_cnt);
    end
    step();
    checks++;
    if (tif.expire !== 1'b0 || tif.busy !== 1'b0 || tif.expire_cnt !== 8'd1) begin
      errors++;
      $display("FAIL zero_after: got expire=%b busy=%b cnt=%0d, want 0/0/1",
               tif.expire, tif.busy, tif.expire_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    tif.start_val = 4'd1; tif.start_valid = 1'b1;
    step();
    tif.start_val = 4'd2;
    #1;
    checks++;
    if (tif.busy !== 1'b1 || tif.start_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: got busy=%b ready=%b, want 1/0", tif.busy, tif.start_ready);
    end
    step();
    checks++;
    if (tif.expire !== 1'b1 || tif.busy !== 1'b0 || tif.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got expire=%b busy=%b ready=%b, want 1/0/1",
               tif.expire, tif.busy, tif.start_ready);
    end
    step();
    tif.start_valid = 1'b0;
    checks++;
    if (tif.count !== 4'd2 || tif.busy !== 1'b1 || tif.expire !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got count=%0d busy=%b expire=%b, want 2/1/0",
               tif.count, tif.busy, tif.expire);
    end
    step();
    step();
    checks++;
    if (tif.expire !== 1'b1 || tif.expire_cnt !== 8'd2) begin
      errors++;
      $display("FAIL b2b_second: got expire=%b cnt=%0d, want 1/2", tif.expire, tif.expire_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_n;
    rst2 = 1'b1;
    #2;
    rst2 = 1'b0;
    sif.start_val = 4'd0; sif.start_valid = 1'b1; sif.reload_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_n = (i >= 3) ? 2'd3 : 2'(i);
      checks++;
      if (sif.expire !== 1'b1 || sif.expire_cnt !== exp_n) begin
        errors++;
        $display("FAIL sat_step%0d: got expire=%b cnt=%0d, want 1/%0d", i, sif.expire, sif.expire_cnt, exp_n);
      end
    end
    sif.start_valid = 1'b0;
    step();
    checks++;
    if (sif.expire !== 1'b0 || sif.expire_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold: got expire=%b cnt=%0d, want 0/3", sif.expire, sif.expire_cnt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    rst2   = 1'b1;
    idle_inputs();
    sif.start_valid = 1'b0;
    sif.start_val   = 4'd0;
    sif.reload_en   = 1'b0;
    sif.pause       = 1'b0;
    sif.abort       = 1'b0;
    test_reset();
    test_oneshot();
    test_reload();
    test_pause();
    test_abort();
    test_async_reset();
    test_zero_start();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
